ram16x4_arbiter: RTL and testbench

- Controller that shares the 16x4 synchronous-read RAM between two requesters: requester 0 (mode-select/UI path) and requester 1 (an internal engine such as a PWM or pattern loader).
- Round-robin arbitration over a valid/ready command handshake.
- Sequences each access onto the RAM's single port and returns read data with a one-cycle valid pulse.
- Contains a clear engine that zero-fills all 16 words on request.

---
 rtl/ram16x4_arbiter_pkg.sv | 17 +
 rtl/ram16x4_arbiter_rr_arb2.sv | 39 +++
 rtl/ram16x4_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ram16x4_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram16x4_arbiter_pkg.sv
// Shared types and constants for the two-requester 16x4 RAM arbiter.
package ram16x4_arbiter_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 4;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      CLEAR   = 2'd3
   } state_e;

endpackage

// File: rtl/ram16x4_arbiter_rr_arb2.sv
// Two-way round-robin grant. The grant is combinational; the last winner is
// remembered only when a grant is actually taken.
module rr_arb2
   import ram16x4_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt_o  = 2'b00;
      last_d = last_q;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_q == REQ1) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
      if (accept_i) begin
         last_d = gnt_o[1];
      end
   end

   // Reset to REQ1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= REQ1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ram16x4_arbiter.sv
// Shares a single-port synchronous-read RAM between two requesters and
// provides a zero-fill clear engine.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting; clear start wins over commands, else grant one request
// ISSUE   | RAM address/data/strobe presented for the accepted command
// WAIT_RD | RD_LAT cycles until RAM read data is captured and returned
// CLEAR   | writing zero to addresses 0..2**ADDR_W-1, one per cycle
module ram16x4_arbiter
   import ram16x4_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_we,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          req_ready,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   input  logic                clr_start,
   output logic                clr_done,
   output logic                busy,
   output logic                ram_we,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   input  logic [DATA_W-1:0]   ram_rdata
);

   localparam int WCNT_W = 2;

   state_e              state_q, state_d;
   logic                cmd_we_q, cmd_we_d;
   logic                cmd_id_q, cmd_id_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                clr_done_q, clr_done_d;

   logic [1:0]          gnt;
   logic                ready_en;
   logic                accept;
   logic                sel_id;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   assign ready_en  = (state_q == IDLE) && !clr_start;
   assign req_ready = ready_en ? gnt : 2'b00;
   assign accept    = |(req_ready & req_valid);

   assign sel_id    = gnt[1];
   assign sel_we    = sel_id ? req_we[1] : req_we[0];
   assign sel_addr  = sel_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
   assign sel_wdata = sel_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req_valid),
      .accept_i (accept),
      .gnt_o    (gnt)
   );

   always_comb begin
      state_d     = state_q;
      cmd_we_d    = cmd_we_q;
      cmd_id_d    = cmd_id_q;
      clr_cnt_d   = clr_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      rsp_valid_d = 2'b00;
      rsp_rdata_d = rsp_rdata_q;
      clr_done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d     = CLEAR;
               ram_we_d    = 1'b1;
               ram_addr_d  = clr_cnt_q;
               ram_wdata_d = '0;
            end else if (accept) begin
               // The RAM port registers double as the captured command.
               state_d     = ISSUE;
               cmd_we_d    = sel_we;
               cmd_id_d    = sel_id;
               ram_we_d    = sel_we;
               ram_addr_d  = sel_addr;
               ram_wdata_d = sel_wdata;
            end
         end

         ISSUE: begin
            if (cmd_we_q) begin
               state_d = IDLE;
            end else begin
               state_d    = WAIT_RD;
               wait_cnt_d = WCNT_W'(RD_LAT - 1);
            end
         end

         WAIT_RD: begin
            if (wait_cnt_q == '0) begin
               state_d               = IDLE;
               rsp_rdata_d           = ram_rdata;
               rsp_valid_d[cmd_id_q] = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end

         CLEAR: begin
            if (clr_cnt_q == '1) begin
               state_d    = IDLE;
               clr_cnt_d  = '0;
               clr_done_d = 1'b1;
            end else begin
               clr_cnt_d   = clr_cnt_q + 1'b1;
               ram_we_d    = 1'b1;
               ram_addr_d  = clr_cnt_q + 1'b1;
               ram_wdata_d = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_we_q    <= 1'b0;
         cmd_id_q    <= REQ0;
         clr_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
         clr_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_we_q    <= cmd_we_d;
         cmd_id_q    <= cmd_id_d;
         clr_cnt_q   <= clr_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         clr_done_q  <= clr_done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_ram16x4_arbiter.sv
// Bench for ram16x4_arbiter: a cycle-scheduled transaction model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ram16x4_arbiter;

   localparam int AW = 4;
   localparam int DW = 4;
   localparam int RD_LAT = 1;
   localparam int SL = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [DW-1:0] rsp_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic          clr_start, clr_done, busy, ram_we;

   always #5 clk = ~clk;

   ram16x4_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clr_start(clr_start),
      .clr_done(clr_done), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // The RAM itself: one-cycle synchronous read.
   logic [DW-1:0] mem [16];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // ---------------- transaction model ----------------
   int          cyc = 0;
   int          m_free = 0;
   logic        m_last = 1'b1;
   logic [3:0]  m_mem [16];
   logic [3:0]  m_rdata = '0;
   logic [3:0]  m_raddr = '0;
   logic        e_we [SL];
   logic        e_drv [SL];
   logic        e_done [SL];
   logic [3:0]  e_addr [SL];
   logic [3:0]  e_wd [SL];
   logic [3:0]  e_rd [SL];
   logic [1:0]  e_rsp [SL];

   function automatic int pick(input logic [1:0] v, input logic last);
      if (v == 2'b01) return 0;
      if (v == 2'b10) return 1;
      return last ? 0 : 1;
   endfunction

   always @(posedge clk) begin
      int cur, e, s, r, sl;
      logic [3:0] a, d;
      cur = cyc;
      e   = cyc + 1;
      s   = cur % SL;
      if (e_rsp[s] != 2'b00) m_rdata = e_rd[s];
      if (e_drv[s] == 1'b1) m_raddr = e_addr[s];
      e_we[s] = 1'b0; e_drv[s] = 1'b0; e_done[s] = 1'b0; e_rsp[s] = 2'b00;
      if (rst) begin
         for (int i = 0; i < SL; i++) begin
            e_we[i] = 1'b0; e_drv[i] = 1'b0; e_done[i] = 1'b0; e_rsp[i] = 2'b00;
            e_addr[i] = '0; e_wd[i] = '0; e_rd[i] = '0;
         end
         m_free  = e;
         m_last  = 1'b1;
         m_rdata = '0;
         m_raddr = '0;
      end else if (cur >= m_free) begin
         if (clr_start) begin
            for (int k = 0; k < 16; k++) begin
               sl = (e + k) % SL;
               e_we[sl] = 1'b1; e_drv[sl] = 1'b1; e_addr[sl] = 4'(k); e_wd[sl] = '0;
               m_mem[k] = '0;
            end
            e_done[(e + 16) % SL] = 1'b1;
            m_free = e + 16;
         end else if (req_valid != 2'b00) begin
            r = pick(req_valid, m_last);
            m_last = (r == 1);
            a = (r == 1) ? req_addr[7:4] : req_addr[3:0];
            d = (r == 1) ? req_wdata[7:4] : req_wdata[3:0];
            sl = e % SL;
            e_drv[sl] = 1'b1; e_addr[sl] = a;
            if (req_we[r]) begin
               e_we[sl] = 1'b1; e_wd[sl] = d;
               m_mem[a] = d;
               m_free = e + 1;
            end else begin
               sl = (e + 1 + RD_LAT) % SL;
               e_rsp[sl] = (r == 1) ? 2'b10 : 2'b01;
               e_rd[sl]  = m_mem[a];
               m_free = e + 1 + RD_LAT;
            end
         end
      end
      cyc = e;
   end

   // ---------------- compare process ----------------
   int n_pass = 0, n_total = 0;
   bit chk_en = 1'b0;
   string lit_nm [256];
   int lit_a [256], lit_e [256];
   int lit_wr = 0, lit_rd = 0;
   logic [3:0] we_a [$], we_d [$];
   int rsp_cnt = 0, rsp1_cnt = 0, last_rsp_cyc = 0, done_cnt = 0, done_cyc = 0;
   logic [3:0] last_rsp_data = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
   endtask

   always @(negedge clk) begin
      int s;
      bit idle;
      logic [1:0] er;
      if (chk_en) begin
         s = cyc % SL;
         idle = (cyc >= m_free);
         er = 2'b00;
         if (idle && !clr_start && req_valid != 2'b00)
            er = (pick(req_valid, m_last) == 1) ? 2'b10 : 2'b01;
         chk("req_ready", 32'(req_ready), 32'(er));
         chk("busy", 32'(busy), 32'(!idle));
         chk("ram_we", 32'(ram_we), 32'(e_we[s]));
         chk("ram_addr", 32'(ram_addr), 32'(e_drv[s] ? e_addr[s] : m_raddr));
         if (e_we[s]) chk("ram_wdata", 32'(ram_wdata), 32'(e_wd[s]));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp[s]));
         chk("rsp_rdata", 32'(rsp_rdata), 32'((e_rsp[s] != 2'b00) ? e_rd[s] : m_rdata));
         chk("clr_done", 32'(clr_done), 32'(e_done[s]));
         if (ram_we) begin we_a.push_back(ram_addr); we_d.push_back(ram_wdata); end
         if (rsp_valid != 2'b00) begin
            rsp_cnt++;
            if (rsp_valid[1]) rsp1_cnt++;
            last_rsp_cyc  = cyc;
            last_rsp_data = rsp_rdata;
         end
         if (clr_done) begin done_cnt++; done_cyc = cyc; end
      end
      while (lit_rd < lit_wr) begin
         chk(lit_nm[lit_rd], 32'(lit_a[lit_rd]), 32'(lit_e[lit_rd]));
         lit_rd++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic lit(input string nm, input int act, input int exp);
      lit_nm[lit_wr] = nm; lit_a[lit_wr] = act; lit_e[lit_wr] = exp;
      lit_wr++;
   endtask

   task automatic set_req(input int r, input bit we, input logic [3:0] a, input logic [3:0] d);
      if (r == 0) begin req_we[0] = we; req_addr[3:0] = a; req_wdata[3:0] = d; end
      else        begin req_we[1] = we; req_addr[7:4] = a; req_wdata[7:4] = d; end
   endtask

   task automatic wait_ready(input int r, output int acc);
      int n;
      acc = -1; n = 0;
      while (acc < 0 && n < 60) begin
         @(negedge clk);
         if (req_ready[r]) acc = cyc;
         n++;
      end
      if (acc < 0) lit("ready_timeout", 0, 1);
   endtask

   task automatic do_cmd(input int r, input bit we, input logic [3:0] a,
                         input logic [3:0] d, output int acc);
      set_req(r, we, a, d);
      req_valid[r] = 1'b1;
      wait_ready(r, acc);
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
   endtask

   initial begin
      int acc, base, bdone, brsp, brsp1, good, n, g;
      int rc [4];
      int gl [$];
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; clr_start = 1'b0;
      cycles(3);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      lit("reset_outputs", {30'd0, busy, ram_we} | 32'(rsp_valid) | 32'(ram_addr) | 32'(clr_done), 0);
      cycles(1);

      // single write then read
      base = we_a.size(); brsp1 = rsp1_cnt;
      do_cmd(0, 1'b1, 4'd3, 4'hA, acc);
      cycles(3);
      lit("wr_we_cycles", we_a.size() - base, 1);
      lit("wr_addr", (we_a.size() > base) ? int'(we_a[base]) : -1, 3);
      do_cmd(0, 1'b0, 4'd3, 4'h0, acc);
      cycles(4);
      lit("rd_latency", last_rsp_cyc - acc, 3);
      lit("rd_data", int'(last_rsp_data), 'hA);
      lit("rd_no_rsp1", rsp1_cnt - brsp1, 0);

      // preload for contention, then reset so r0 wins first tie
      do_cmd(0, 1'b1, 4'd1, 4'h5, acc);
      do_cmd(0, 1'b1, 4'd2, 4'h6, acc);
      cycles(2);
      pulse_reset();
      brsp1 = rsp1_cnt; brsp = rsp_cnt;
      set_req(0, 1'b0, 4'd1, 4'h0);
      set_req(1, 1'b0, 4'd2, 4'h0);
      req_valid = 2'b11;
      n = 0;
      while (gl.size() < 4 && n < 60) begin
         @(negedge clk);
         if ((req_ready & req_valid) != 2'b00) gl.push_back(req_ready[1] ? 1 : 0);
         n++;
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      cycles(5);
      for (int i = 0; i < 4; i++) lit("grant_order", (gl.size() > i) ? gl[i] : -1, i % 2);
      lit("contention_rsp1", rsp1_cnt - brsp1, 2);
      lit("contention_rsp", rsp_cnt - brsp, 4);

      // back-to-back writes from r1
      set_req(1, 1'b1, 4'd4, 4'd1);
      req_valid[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ready(1, rc[i]);
         @(posedge clk); #1;
         if (i < 3) set_req(1, 1'b1, 4'(5 + i), 4'(2 + i));
         else req_valid[1] = 1'b0;
      end
      cycles(3);
      for (int i = 0; i < 3; i++) lit("b2b_ready_gap", rc[i+1] - rc[i], 2);
      for (int i = 0; i < 4; i++) lit("b2b_mem", int'(mem[4+i]), 1 + i);

      // fill with 0xF, then clear racing a valid r0 read
      for (int i = 0; i < 16; i++) do_cmd(0, 1'b1, 4'(i), 4'hF, acc);
      cycles(2);
      base = we_a.size(); bdone = done_cnt;
      set_req(0, 1'b0, 4'd5, 4'h0);
      clr_start = 1'b1; req_valid[0] = 1'b1;
      cycles(1);
      clr_start = 1'b0;
      wait_ready(0, acc);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      cycles(5);
      lit("clr_we_cycles", we_a.size() - base, 16);
      good = 0;
      for (int k = 0; k < 16; k++)
         if (we_a.size() > base + k && we_a[base+k] == 4'(k) && we_d[base+k] == 4'h0) good++;
      lit("clr_addr_seq", good, 16);
      lit("clr_done_pulses", done_cnt - bdone, 1);
      lit("clr_then_accept", acc, done_cyc);
      lit("clr_readback", int'(last_rsp_data), 0);

      // clear request during WAIT_RD is ignored
      do_cmd(0, 1'b1, 4'd9, 4'h7, acc);
      cycles(1);
      base = we_a.size(); bdone = done_cnt; brsp = rsp_cnt;
      do_cmd(0, 1'b0, 4'd9, 4'h0, acc);
      cycles(1);
      clr_start = 1'b1;
      cycles(1);
      clr_start = 1'b0;
      cycles(20);
      lit("ign_clr_no_we", we_a.size() - base, 0);
      lit("ign_clr_no_done", done_cnt - bdone, 0);
      lit("ign_clr_rsp", rsp_cnt - brsp, 1);
      lit("ign_clr_data", int'(last_rsp_data), 7);

      // reset during WAIT_RD
      brsp = rsp_cnt;
      do_cmd(1, 1'b0, 4'd9, 4'h0, acc);
      cycles(1);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      @(negedge clk);
      lit("rst_busy", int'(busy), 0);
      lit("rst_outs", int'({rsp_valid, ram_we, clr_done, req_ready}), 0);
      lit("rst_ram_addr", int'(ram_addr), 0);
      lit("rst_rdata", int'(rsp_rdata), 0);
      cycles(10);
      lit("rst_no_rsp", rsp_cnt - brsp, 0);
      set_req(0, 1'b0, 4'd1, 4'h0);
      set_req(1, 1'b0, 4'd2, 4'h0);
      req_valid = 2'b11;
      g = -1; n = 0;
      while (g < 0 && n < 20) begin
         @(negedge clk);
         if ((req_ready & req_valid) != 2'b00) g = req_ready[1] ? 1 : 0;
         n++;
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      lit("rst_first_tie", g, 0);
      cycles(6);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
